match_seq_lock: RTL and testbench
=================================

# match_seq_lock

Sequential consumer of the 2-bit match code from the three-way comparator stage (`00` = no match, `01`/`10`/`11` = first/second/third reference matched). The block checks that matches arrive in the order `01` → `10` → `11`. A correct sequence produces a timed unlock window. Wrong steps are counted, and after a configurable number of failures the block locks out until reset.

## Interface
Parameters:
- `HOLD`, default 4: unlock window length in clock cycles; must be ≥1.
- `MAX_FAILS`, default 3: failed attempts before lockout; must be ≥1.
- `CNT_W`, default 4: width of each hit counter.

Ports (one clock `clk`; `rst` is synchronous and active-high; all outputs registered):
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: synchronous active-high reset.
- `valid`, input, 1: `code` is sampled on this edge.
- `code`, input, 2: match code from the comparator stage.
- `unlock`, output, 1: high during the unlock window.
- `error`, output, 1: one-cycle pulse on each failed attempt.
- `lockout`, output, 1: high while in lockout.
- `fail_cnt`, output, 2: current failed-attempt count.
- `hits1`, `hits2`, `hits3`, output, `CNT_W` each: saturating counts of accepted `01`/`10`/`11` codes.

## Operation
- States: IDLE, GOT1, GOT2, OPEN, LOCK. Reset state is IDLE.
- Reset values: all outputs 0; hold timer 0.
- A code is accepted only when `valid` = 1 and the state is IDLE, GOT1 or GOT2.
- In OPEN and LOCK, `valid` is ignored and hit counters do not change.
- An accepted `code` = `00` means no match and is ignored; state is held.
- IDLE transitions:
  - `01` → GOT1.
  - `10` or `11` → fail.
- GOT1 transitions:
  - `10` → GOT2.
  - `01` → GOT1 (restart).
  - `11` → fail.
- GOT2 transitions:
  - `11` → OPEN. `fail_cnt` is cleared and the timer is loaded with `HOLD`-1.
  - `01` → GOT1.
  - `10` → GOT2 (hold).
- On fail:
  - `error` pulses for one cycle.
  - `fail_cnt` increments.
  - If the new count equals `MAX_FAILS` → LOCK, otherwise → IDLE.
- OPEN: `unlock` = 1. The timer decrements each cycle; at 0 the state returns to IDLE.
- LOCK: `lockout` = 1. Only `rst` leaves LOCK.
- Hit counters:
  - Each accepted nonzero code increments its counter, including codes that cause a fail.
  - Counters saturate at 2^`CNT_W`-1 and do not wrap.
  - Counters are not cleared by unlock; only `rst` clears them.
- `fail_cnt` saturates at `MAX_FAILS` and is cleared only by a successful unlock or `rst`.

## Timing
- Latency: `code` accepted at edge N → state and outputs update at edge N (visible in cycle N+1).
- `unlock` rises in the cycle after the `11` is accepted and stays high for exactly `HOLD` cycles.
- `error` is high for exactly one cycle per fail, coincident with the state change to IDLE or LOCK.
- `lockout` rises in the same cycle as the final `error` pulse.
- Back-to-back `valid` codes are accepted every cycle; there is no backpressure.
- `rst` has priority over every other event. Reset in any state, including mid-OPEN or LOCK, forces IDLE and all outputs to 0 at that edge.

## Configuration
- `MATCH_SEQ_STATS_EN` defined: `hits1`/`hits2`/`hits3` counters are implemented as described above.
- Not defined: counter logic is omitted and `hits1`/`hits2`/`hits3` are constant 0.
- The FSM, `unlock`, `error`, `lockout` and `fail_cnt` are identical in both builds.

## Test plan
- Correct sequence, default parameters: reset, then `valid` with codes `01`, `00`, `10`, `11` on consecutive cycles.
  - Expect `unlock` = 1 for 4 cycles, then IDLE.
  - Expect `hits1` = `hits2` = `hits3` = 1, `error` never asserted, `fail_cnt` = 0.
- Single fail: `01` then `11`.
  - Expect a one-cycle `error` pulse, `fail_cnt` = 1, state IDLE.
  - A following `01`, `10`, `11` unlocks and clears `fail_cnt` to 0.
- Lockout: three sequences `10` (fail each), with `MAX_FAILS` = 3.
  - Expect `lockout` = 1 after the third `error` pulse.
  - A later `01`, `10`, `11` produces no `unlock` and leaves the hit counters unchanged.
  - `rst` returns all outputs to 0.
- Restart and hold: sequence `01`, `10`, `01`, `10`, `10`, `11`.
  - Expect an unlock with no `error`.
  - Expect `hits2` = 3.
- Saturation and reset mid-window, with `CNT_W` = 2 and `MATCH_SEQ_STATS_EN` defined:
  - Six accepted `01` codes → `hits1` = 3.
  - Assert `rst` in the 2nd cycle of an OPEN window → `unlock` = 0 in the next cycle and all counters 0.
  - Repeat with the macro undefined → hit outputs stay 0 throughout.

Source files
------------

// File: rtl/match_seq_lock.sv
// match_seq_lock: checks 01->10->11 match order, opens a timed unlock window, locks out after repeated failures.
// Define MATCH_SEQ_STATS_EN to build the saturating hits1/hits2/hits3 counters; otherwise they read 0.
module match_seq_lock #(
  parameter int HOLD      = 4,
  parameter int MAX_FAILS = 3,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       code,
  output logic             unlock,
  output logic             error,
  output logic             lockout,
  output logic [1:0]       fail_cnt,
  output logic [CNT_W-1:0] hits1,
  output logic [CNT_W-1:0] hits2,
  output logic [CNT_W-1:0] hits3
);
  typedef enum logic [2:0] {IDLE, GOT1, GOT2, OPEN, LOCK} state_t;
  localparam int TW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(HOLD - 1);
  localparam logic [2:0] MF = 3'(MAX_FAILS);
  state_t r_state, w_next;
  logic [TW-1:0] r_timer, w_timer;
  logic [1:0] r_fail_cnt, w_fail_cnt;
  logic [2:0] w_fail_inc;
  logic r_unlock, r_error, r_lockout;
  logic w_accept, w_fail;
  always_comb begin
    w_accept   = valid && (r_state == IDLE || r_state == GOT1 || r_state == GOT2);
    w_fail_inc = {1'b0, r_fail_cnt} + 3'd1;
    w_next     = r_state;
    w_timer    = r_timer;
    w_fail     = 1'b0;
    w_fail_cnt = r_fail_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept && code == 2'b01) w_next = GOT1;
        else if (w_accept && code != 2'b00) w_fail = 1'b1;
      end
      GOT1: begin
        if (w_accept && code == 2'b10) w_next = GOT2;
        else if (w_accept && code == 2'b11) w_fail = 1'b1;
      end
      GOT2: begin
        if (w_accept && code == 2'b01) w_next = GOT1;
        else if (w_accept && code == 2'b11) begin
          w_next     = OPEN;
          w_timer    = T_LOAD;
          w_fail_cnt = 2'd0;
        end
      end
      OPEN: begin
        w_timer = r_timer == '0 ? '0 : r_timer - TW'(1);
        w_next  = r_timer == '0 ? IDLE : OPEN;
      end
      default: w_next = r_state;
    endcase
    // fail_cnt never needs to exceed MAX_FAILS: reaching it parks the FSM in LOCK
    if (w_fail) begin
      w_fail_cnt = w_fail_inc >= MF ? MF[1:0] : w_fail_inc[1:0];
      w_next     = w_fail_inc >= MF ? LOCK : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_fail_cnt <= 2'd0;
      r_unlock   <= 1'b0;
      r_error    <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_timer    <= w_timer;
      r_fail_cnt <= w_fail_cnt;
      r_unlock   <= w_next == OPEN;
      r_error    <= w_fail;
      r_lockout  <= w_next == LOCK;
    end
  end
  assign unlock   = r_unlock;
  assign error    = r_error;
  assign lockout  = r_lockout;
  assign fail_cnt = r_fail_cnt;
`ifdef MATCH_SEQ_STATS_EN
  logic [CNT_W-1:0] r_hits [3];
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) r_hits[k] <= '0;
      else if (w_accept && code == 2'(k + 1) && r_hits[k] != '1) r_hits[k] <= r_hits[k] + CNT_W'(1);
    end
  end
  assign hits1 = r_hits[0];
  assign hits2 = r_hits[1];
  assign hits3 = r_hits[2];
`else
  assign hits1 = '0;
  assign hits2 = '0;
  assign hits3 = '0;
`endif
endmodule

// File: tb/tb_match_seq_lock.sv
// tb_match_seq_lock: two configurations driven in parallel and compared each cycle against a sequence-level model.
module tb_match_seq_lock;
  logic clk = 1'b0;
  logic rst = 1'b1, valid = 1'b0;
  logic [1:0] code = 2'b00;
  logic [1:0] unl, err, lck;
  logic [1:0] fc [2];
  logic [3:0] ha [3];
  logic [1:0] hb [3];
  int checks = 0, errs = 0;
  int p_hold [2] = '{4, 2};
  int p_mf [2] = '{3, 2};
  int p_max [2] = '{15, 3};
  int m_prog [2], m_open [2], m_lock [2], m_fails [2], m_err [2];
  int m_hits [2][3];

  always #5 clk = ~clk;

  match_seq_lock u_a (
    .clk(clk), .rst(rst), .valid(valid), .code(code),
    .unlock(unl[0]), .error(err[0]), .lockout(lck[0]), .fail_cnt(fc[0]),
    .hits1(ha[0]), .hits2(ha[1]), .hits3(ha[2])
  );

  match_seq_lock #(.HOLD(2), .MAX_FAILS(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .valid(valid), .code(code),
    .unlock(unl[1]), .error(err[1]), .lockout(lck[1]), .fail_cnt(fc[1]),
    .hits1(hb[0]), .hits2(hb[1]), .hits3(hb[2])
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int exp_hits(input int k, input int j);
`ifdef MATCH_SEQ_STATS_EN
    return m_hits[k][j];
`else
    return 0;
`endif
  endfunction

  // Progress counts how many of 01,10,11 have been seen in order; open counts remaining window cycles.
  task automatic step_model(input logic r, input logic v, input logic [1:0] c);
    for (int k = 0; k < 2; k++) begin
      logic f;
      f = 1'b0;
      m_err[k] = 0;
      if (r) begin
        m_prog[k] = 0; m_open[k] = 0; m_lock[k] = 0; m_fails[k] = 0;
        for (int j = 0; j < 3; j++) m_hits[k][j] = 0;
      end else if (m_open[k] > 0) begin
        m_open[k]--;
      end else if (m_lock[k] == 0 && v && c != 2'b00) begin
        if (m_hits[k][c-1] < p_max[k]) m_hits[k][c-1]++;
        if (c == 2'b01) m_prog[k] = 1;
        else if (c == 2'b10) begin
          if (m_prog[k] >= 1) m_prog[k] = 2;
          else f = 1'b1;
        end else begin
          if (m_prog[k] == 2) begin
            m_open[k] = p_hold[k];
            m_fails[k] = 0;
            m_prog[k] = 0;
          end else f = 1'b1;
        end
        if (f) begin
          m_err[k] = 1;
          m_prog[k] = 0;
          m_fails[k]++;
          if (m_fails[k] >= p_mf[k]) m_lock[k] = 1;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [1:0] c);
    rst = r; valid = v; code = c;
    @(posedge clk);
    step_model(r, v, c);
    #1;
    chk("unlock_a", int'(unl[0]), int'(m_open[0] > 0));
    chk("error_a", int'(err[0]), m_err[0]);
    chk("lockout_a", int'(lck[0]), m_lock[0]);
    chk("fail_cnt_a", int'(fc[0]), m_fails[0]);
    chk("unlock_b", int'(unl[1]), int'(m_open[1] > 0));
    chk("error_b", int'(err[1]), m_err[1]);
    chk("lockout_b", int'(lck[1]), m_lock[1]);
    chk("fail_cnt_b", int'(fc[1]), m_fails[1]);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("hits%0d_a", j + 1), int'(ha[j]), exp_hits(0, j));
      chk($sformatf("hits%0d_b", j + 1), int'(hb[j]), exp_hits(1, j));
    end
  endtask

  initial begin
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, 0); cyc(0, 1, 2); cyc(0, 1, 3);
    repeat (6) cyc(0, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, 3);
    cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 3);
    repeat (6) cyc(0, 0, 0);
    repeat (3) cyc(0, 1, 2);
    cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 3);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 1); cyc(0, 1, 2); cyc(0, 1, 2); cyc(0, 1, 3);
    repeat (5) cyc(0, 0, 0);
    repeat (20) cyc(0, 1, 1);
    cyc(0, 1, 2); cyc(0, 1, 3);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (3000) begin
      logic r, v;
      logic [1:0] c;
      r = $urandom_range(0, 63) == 0;
      v = $urandom_range(0, 3) != 0;
      c = 2'($urandom_range(0, 3));
      cyc(r, v, c);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
